// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared widths and FSM state encodings for the sequential
// restoring divider and anything that talks to it.
package seq_divider_pkg;

  localparam int DEF_WIDTH_N = 32;  // dividend / quotient width
  localparam int DEF_WIDTH_D = 16;  // divisor / remainder width

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step. The partial remainder
// is shifted left with the next dividend bit appended; if the result is not
// below the divisor, the divisor is subtracted and the quotient bit is 1.
module div_step #(
  parameter int WIDTH_D = 16
) (
  input  logic [WIDTH_D:0]   rem_in,
  input  logic               bit_in,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D:0]   rem_out,
  output logic               q_bit
);

  logic [WIDTH_D+1:0] shifted_s;
  logic [WIDTH_D+1:0] divisor_ext_s;

  // Shift-in, trial compare and conditional subtract for a single quotient bit
  always_comb begin
    shifted_s     = {rem_in, bit_in};
    divisor_ext_s = {2'b00, divisor};
    if (shifted_s >= divisor_ext_s) begin
      rem_out = (WIDTH_D + 1)'(shifted_s - divisor_ext_s);
      q_bit   = 1'b1;
    end else begin
      // A zero divisor always takes the branch above, so the remainder
      // register simply collects the low dividend bits in that case.
      rem_out = (WIDTH_D + 1)'(shifted_s);
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned sequential restoring divider, one quotient bit per
// cycle, MSB first. Result is strobed by a one-cycle valid.
// Optional feature macro: SEQ_DIVIDER_DIVZERO_EN -- when defined, a zero
// divisor skips the iteration, returns in one cycle and raises div_zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               valid,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_zero
);

  localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_N - 1);

  div_state_t         state_r;
  div_state_t         state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH_N-1:0] dvd_r;        // dividend shifts out MSB first, quotient shifts in
  logic [WIDTH_D-1:0] dsr_r;
  logic [WIDTH_D:0]   rem_r;        // partial remainder, one bit wider than divisor
  logic [WIDTH_N-1:0] quotient_r;
  logic [WIDTH_D-1:0] remainder_r;
  logic               div_zero_r;

  logic               accept_s;
  logic               zero_start_s;
  logic               last_step_s;
  logic [WIDTH_D:0]   step_rem_s;
  logic               step_q_s;
  logic               busy_s;
  logic               valid_s;

  assign accept_s    = start && ((state_r == DIV_IDLE) || (state_r == DIV_DONE));
  assign last_step_s = (state_r == DIV_CALC) && (cnt_r == CNT_LAST);

`ifdef SEQ_DIVIDER_DIVZERO_EN
  assign zero_start_s = accept_s && (divisor == {WIDTH_D{1'b0}});
`else
  assign zero_start_s = 1'b0;
`endif

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[WIDTH_N-1]),
    .divisor (dsr_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // State register; reset takes priority over a simultaneous start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: start is only honoured from IDLE or DONE
  always_comb begin
    state_s = state_r;
    case (state_r)
      DIV_IDLE, DIV_DONE: begin
        if (start) begin
          if (zero_start_s) begin
            state_s = DIV_DONE;
          end else begin
            state_s = DIV_CALC;
          end
        end else begin
          state_s = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        if (last_step_s) begin
          state_s = DIV_DONE;
        end else begin
          state_s = DIV_CALC;
        end
      end
      default: begin
        state_s = DIV_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state register
  always_comb begin
    busy_s  = 1'b0;
    valid_s = 1'b0;
    case (state_r)
      DIV_CALC: begin
        busy_s  = 1'b1;
        valid_s = 1'b0;
      end
      DIV_DONE: begin
        busy_s  = 1'b0;
        valid_s = 1'b1;
      end
      default: begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration datapath and held result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      dvd_r       <= {WIDTH_N{1'b0}};
      dsr_r       <= {WIDTH_D{1'b0}};
      rem_r       <= {(WIDTH_D + 1){1'b0}};
      quotient_r  <= {WIDTH_N{1'b0}};
      remainder_r <= {WIDTH_D{1'b0}};
      div_zero_r  <= 1'b0;
    end else begin
      // div_zero is a strobe that accompanies valid only
      div_zero_r <= 1'b0;
      if (accept_s) begin
        cnt_r <= {CNT_W{1'b0}};
        dvd_r <= dividend;
        dsr_r <= divisor;
        rem_r <= {(WIDTH_D + 1){1'b0}};
        if (zero_start_s) begin
          quotient_r  <= {WIDTH_N{1'b1}};
          remainder_r <= dividend[WIDTH_D-1:0];
          div_zero_r  <= 1'b1;
        end else begin
          quotient_r  <= quotient_r;
          remainder_r <= remainder_r;
        end
      end else if (state_r == DIV_CALC) begin
        cnt_r <= cnt_r + CNT_ONE;
        dvd_r <= {dvd_r[WIDTH_N-2:0], step_q_s};
        rem_r <= step_rem_s;
        if (last_step_s) begin
          quotient_r  <= {dvd_r[WIDTH_N-2:0], step_q_s};
          remainder_r <= step_rem_s[WIDTH_D-1:0];
        end else begin
          quotient_r  <= quotient_r;
          remainder_r <= remainder_r;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign busy      = busy_s;
  assign valid     = valid_s;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven bench with a result scoreboard for seq_divider.
// Honours SEQ_DIVIDER_DIVZERO_EN to select the expected zero-divisor behaviour.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int WN = DEF_WIDTH_N;
  localparam int WD = DEF_WIDTH_D;
  localparam int LAT_NORMAL = 32;  // edges from accept edge to result edge
`ifdef SEQ_DIVIDER_DIVZERO_EN
  localparam int LAT_DZ = 0;       // result registered on the accept edge itself
  localparam logic DZ_FLAG = 1'b1;
`else
  localparam int LAT_DZ = 32;
  localparam logic DZ_FLAG = 1'b0;
`endif

  typedef struct {
    logic [WN-1:0] dvd;
    logic [WD-1:0] dsr;
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dz;
    int            lat;
  } vec_t;

  typedef struct {
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dz;
    int            start_edge;
    int            lat;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic          busy;
  logic          valid;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;
  logic          div_zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  vec_t vecs[8];

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at the negedge following edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: pops the scoreboard on every valid strobe
  always @(negedge clk) begin
    if (valid) begin
      check("valid_busy_low", {63'd0, busy}, 64'd0);
      check("valid_single_cycle", {63'd0, prev_valid}, 64'd0);
      check("valid_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        check("latency", 64'(cyc - e.start_edge), 64'(e.lat));
      end
    end
    prev_valid = valid;
  end

  // Called at a negedge; start is accepted on the following posedge
  task automatic drive_start(input logic [WN-1:0] a, input logic [WD-1:0] b,
                             input logic [WN-1:0] q, input logic [WD-1:0] r,
                             input logic dz, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.start_edge = cyc + 1; e.lat = lat;
    sb.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk);
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{dvd: 32'd1000,       dsr: 16'd7,      q: 32'd142,        r: 16'd6,   dz: 1'b0,    lat: LAT_NORMAL};
    vecs[1] = '{dvd: 32'd496,        dsr: 16'd31,     q: 32'd16,         r: 16'd0,   dz: 1'b0,    lat: LAT_NORMAL};
    vecs[2] = '{dvd: 32'hFFFF_FFFF,  dsr: 16'd1,      q: 32'hFFFF_FFFF,  r: 16'd0,   dz: 1'b0,    lat: LAT_NORMAL};
    vecs[3] = '{dvd: 32'd5,          dsr: 16'hFFFF,   q: 32'd0,          r: 16'd5,   dz: 1'b0,    lat: LAT_NORMAL};
    vecs[4] = '{dvd: 32'd100,        dsr: 16'd0,      q: 32'hFFFF_FFFF,  r: 16'd100, dz: DZ_FLAG, lat: LAT_DZ};
    vecs[5] = '{dvd: 32'h8000_0000,  dsr: 16'h8000,   q: 32'h0001_0000,  r: 16'd0,   dz: 1'b0,    lat: LAT_NORMAL};
    vecs[6] = '{dvd: 32'h1234_5678,  dsr: 16'hABCD,   q: 32'h1234_5678 / 32'h0000_ABCD,
                r: 16'(32'h1234_5678 % 32'h0000_ABCD), dz: 1'b0, lat: LAT_NORMAL};
    vecs[7] = '{dvd: 32'hDEAD_BEEF,  dsr: 16'h0000,   q: 32'hFFFF_FFFF,  r: 16'hBEEF, dz: DZ_FLAG, lat: LAT_DZ};

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      drive_start(vecs[i].dvd, vecs[i].dsr, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
      check("busy_after_start", {63'd0, busy}, {63'd0, vecs[i].lat != 0});
      if (i > 0 && vecs[i].lat != 0)
        check("no_clear_on_start", 64'(quotient), 64'(vecs[i-1].q));
      wait_drain(LAT_NORMAL + 10);
      @(negedge clk);
      check("result_held_q", 64'(quotient), 64'(vecs[i].q));
      check("result_held_r", 64'(remainder), 64'(vecs[i].r));
      check("idle_not_busy", {63'd0, busy}, 64'd0);
    end

    // Ignored start mid-CALC, then back-to-back start in the valid cycle
    drive_start(32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, LAT_NORMAL);
    k = cyc;
    while (cyc < k + 9) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", {63'd0, busy}, 64'd1);
    check("ignored_start_sb", 64'(sb.size()), 64'd1);
    for (int n = 0; n < LAT_NORMAL + 10 && !valid; n++) @(negedge clk);
    check("first_valid_seen", {63'd0, valid}, 64'd1);
    if (valid) begin
      drive_start(32'd9, 16'd3, 32'd3, 16'd0, 1'b0, LAT_NORMAL);
      check("b2b_busy", {63'd0, busy}, 64'd1);
    end
    wait_drain(LAT_NORMAL + 10);
    repeat (5) @(negedge clk);

    // Reset in the middle of a calculation discards it
    drive_start(32'd1000, 16'd7, 32'd142, 16'd6, 1'b0, LAT_NORMAL);
    k = cyc;
    while (cyc < k + 14) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_valid", {63'd0, valid}, 64'd0);
    check("midrst_quotient", 64'(quotient), 64'd0);
    check("midrst_remainder", 64'(remainder), 64'd0);
    check("midrst_div_zero", {63'd0, div_zero}, 64'd0);
    repeat (40) @(negedge clk);
    check("midrst_stays_idle", {63'd0, busy}, 64'd0);
    drive_start(32'd20, 16'd6, 32'd3, 16'd2, 1'b0, LAT_NORMAL);
    wait_drain(LAT_NORMAL + 10);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
